// File: rtl/ysyx_24110015_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between the IFU and the LSU.
// Only one transaction is in flight; a stalled memory is cut off by a timeout error response.
module ysyx_24110015_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_resp_data,
    output logic        ifu_resp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_resp_data,
    output logic        lsu_resp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_resp_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;
    // The counter starts at 0 in the first REQ cycle, so RESP lands TIMEOUT cycles later.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             owner;
    logic [31:0]      addr_q;
    logic             wen_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wmask_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic grant_ifu;
    logic grant_lsu;
    logic timed_out;
    logic owner_resp_ready;

    always_comb begin
        grant_lsu = (state == S_IDLE) && !rst && lsu_req_valid &&
                    (!ifu_req_valid || (last_grant == OWN_IFU));
        grant_ifu = (state == S_IDLE) && !rst && ifu_req_valid &&
                    (!lsu_req_valid || (last_grant == OWN_LSU));
        timed_out = (cnt >= CNT_LAST);
        owner_resp_ready = (owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;

    assign mem_req_valid  = (state == S_REQ);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign mem_resp_ready = (state == S_WAIT);

    assign ifu_resp_valid = (state == S_RESP) && (owner == OWN_IFU);
    assign ifu_resp_data  = ifu_resp_valid ? rdata_q : 32'h0;
    assign ifu_resp_err   = ifu_resp_valid & err_q;
    assign lsu_resp_valid = (state == S_RESP) && (owner == OWN_LSU);
    assign lsu_resp_data  = lsu_resp_valid ? rdata_q : 32'h0;
    assign lsu_resp_err   = lsu_resp_valid & err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_grant <= OWN_IFU;
            owner      <= OWN_IFU;
            addr_q     <= 32'h0;
            wen_q      <= 1'b0;
            wdata_q    <= 32'h0;
            wmask_q    <= 4'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_lsu) begin
                        owner      <= OWN_LSU;
                        last_grant <= OWN_LSU;
                        addr_q     <= lsu_addr;
                        wen_q      <= lsu_wen;
                        wdata_q    <= lsu_wdata;
                        wmask_q    <= lsu_wmask;
                        cnt        <= '0;
                        state      <= S_REQ;
                    end else if (grant_ifu) begin
                        owner      <= OWN_IFU;
                        last_grant <= OWN_IFU;
                        addr_q     <= ifu_addr;
                        wen_q      <= 1'b0;
                        wdata_q    <= 32'h0;
                        wmask_q    <= 4'h0;
                        cnt        <= '0;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_req_ready) begin
                        state <= S_WAIT;
                    end else if (timed_out) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                        state   <= S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // A response in the timeout cycle still counts as a normal completion.
                    if (mem_resp_valid) begin
                        rdata_q <= mem_resp_data;
                        err_q   <= 1'b0;
                        state   <= S_RESP;
                    end else if (timed_out) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (owner_resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Directed self-checking bench for the IFU/LSU memory arbiter: latency, round-robin,
// write stalls, response back-pressure, reset abandonment and timeout behaviour.
module tb_ysyx_24110015_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_resp_data;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_resp_data;
    logic [3:0]  mem_wmask;

    int total = 0;
    int bad   = 0;

    ysyx_24110015_mem_arbiter #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one zero-wait transaction whose grant was made in the current cycle.
    task automatic applyStimulus(input bit is_lsu, input logic [31:0] exp_addr,
                                 input logic [31:0] rdata, input string tag);
        nextCycle();
        if (is_lsu) lsu_req_valid = 1'b0;
        else        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checkOutput({tag, "_memvalid"}, mem_req_valid, 1'b1);
        checkOutput({tag, "_memaddr"}, mem_addr, exp_addr);
        checkOutput({tag, "_noready"}, ifu_req_ready | lsu_req_ready, 1'b0);
        nextCycle();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = rdata;
        #1;
        checkOutput({tag, "_respready"}, mem_resp_ready, 1'b1);
        nextCycle();
        mem_resp_valid = 1'b0;
        #1;
        checkOutput({tag, "_ifuvalid"}, ifu_resp_valid, !is_lsu);
        checkOutput({tag, "_lsuvalid"}, lsu_resp_valid, is_lsu);
        checkOutput({tag, "_data"}, is_lsu ? lsu_resp_data : ifu_resp_data, rdata);
        nextCycle();
    endtask

    initial begin
        logic early;
        logic held_bad;

        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h0; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0;
        lsu_wmask = 4'h0; lsu_resp_ready = 1'b1;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        nextCycle();
        nextCycle();
        checkOutput("rst_ifu_ready", ifu_req_ready, 1'b0);
        checkOutput("rst_mem_valid", mem_req_valid, 1'b0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_resp_valid", ifu_resp_valid | lsu_resp_valid, 1'b0);

        $display("[TB] IFU single fetch latency");
        rst = 1'b0;
        ifu_addr = 32'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        checkOutput("f_ifu_ready", ifu_req_ready, 1'b1);
        checkOutput("f_lsu_ready", lsu_req_ready, 1'b0);
        nextCycle();
        ifu_req_valid = 1'b0;
        ifu_addr = 32'h1234_5678;
        #1;
        checkOutput("f_c1_memvalid", mem_req_valid, 1'b1);
        checkOutput("f_c1_addr", mem_addr, 32'h8000_0000);
        checkOutput("f_c1_wen", mem_wen, 1'b0);
        checkOutput("f_c1_wmask", mem_wmask, 4'h0);
        nextCycle();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h0000_0413;
        #1;
        checkOutput("f_c2_respready", mem_resp_ready, 1'b1);
        checkOutput("f_c2_memvalid", mem_req_valid, 1'b0);
        checkOutput("f_c2_ifuvalid", ifu_resp_valid, 1'b0);
        nextCycle();
        mem_resp_valid = 1'b0;
        #1;
        checkOutput("f_c3_ifuvalid", ifu_resp_valid, 1'b1);
        checkOutput("f_c3_data", ifu_resp_data, 32'h0000_0413);
        checkOutput("f_c3_err", ifu_resp_err, 1'b0);
        checkOutput("f_c3_lsuvalid", lsu_resp_valid, 1'b0);
        checkOutput("f_c3_lsudata", lsu_resp_data, 32'h0);
        nextCycle();
        #1;
        checkOutput("f_c4_ifuvalid", ifu_resp_valid, 1'b0);

        $display("[TB] round-robin after reset");
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0;
        #1;
        checkOutput("rr1_lsu_ready", lsu_req_ready, 1'b1);
        checkOutput("rr1_ifu_ready", ifu_req_ready, 1'b0);
        applyStimulus(1'b1, 32'h8000_3000, 32'h0000_00A1, "rr1");
        #1;
        checkOutput("rr2_ifu_ready", ifu_req_ready, 1'b1);
        checkOutput("rr2_lsu_ready", lsu_req_ready, 1'b0);
        applyStimulus(1'b0, 32'h8000_0300, 32'h0000_00A2, "rr2");
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        checkOutput("rr3_lsu_ready", lsu_req_ready, 1'b1);
        checkOutput("rr3_ifu_ready", ifu_req_ready, 1'b0);
        applyStimulus(1'b1, 32'h8000_3000, 32'h0000_00A3, "rr3");
        lsu_req_valid = 1'b1;
        #1;
        checkOutput("rr4_ifu_ready", ifu_req_ready, 1'b1);
        checkOutput("rr4_lsu_ready", lsu_req_ready, 1'b0);
        applyStimulus(1'b0, 32'h8000_0300, 32'h0000_00A4, "rr4");
        #1;
        checkOutput("rr5_lsu_ready", lsu_req_ready, 1'b1);
        applyStimulus(1'b1, 32'h8000_3000, 32'h0000_00A5, "rr5");

        $display("[TB] LSU write with stalled memory");
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        #1;
        checkOutput("wr_grant", lsu_req_ready, 1'b1);
        nextCycle();
        lsu_req_valid = 1'b0; lsu_addr = 32'h0BAD_0BAD; lsu_wdata = 32'h5555_5555;
        lsu_wmask = 4'h1; lsu_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            #1;
            checkOutput("wr_valid", mem_req_valid, 1'b1);
            checkOutput("wr_addr", mem_addr, 32'h8000_1000);
            checkOutput("wr_wen", mem_wen, 1'b1);
            checkOutput("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
            checkOutput("wr_wmask", mem_wmask, 4'hF);
            nextCycle();
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h0000_0001;
        #1;
        checkOutput("wr_wait_memvalid", mem_req_valid, 1'b0);
        nextCycle();
        mem_resp_valid = 1'b0;
        #1;
        checkOutput("wr_resp_valid", lsu_resp_valid, 1'b1);
        checkOutput("wr_resp_data", lsu_resp_data, 32'h0000_0001);
        checkOutput("wr_resp_err", lsu_resp_err, 1'b0);
        checkOutput("wr_ifu_idle", ifu_resp_valid, 1'b0);
        nextCycle();
        #1;
        checkOutput("wr_single_resp", lsu_resp_valid, 1'b0);

        $display("[TB] response back-pressure then reset in WAIT");
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
        #1;
        checkOutput("bp_grant", ifu_req_ready, 1'b1);
        nextCycle();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        nextCycle();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h1122_3344;
        nextCycle();
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_wmask = 4'h0;
        held_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h1122_3344 ||
                lsu_req_ready !== 1'b0)
                held_bad = 1'b1;
            nextCycle();
        end
        checkOutput("bp_held_stable", held_bad, 1'b0);
        ifu_resp_ready = 1'b1;
        #1;
        checkOutput("bp_release_valid", ifu_resp_valid, 1'b1);
        checkOutput("bp_release_data", ifu_resp_data, 32'h1122_3344);
        nextCycle();
        #1;
        checkOutput("bp_next_grant", lsu_req_ready, 1'b1);
        checkOutput("bp_ifu_done", ifu_resp_valid, 1'b0);
        nextCycle();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checkOutput("rw_req_addr", mem_addr, 32'h8000_2000);
        nextCycle();
        mem_req_ready = 1'b0;
        #1;
        checkOutput("rw_in_wait", mem_resp_ready, 1'b1);
        rst = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        checkOutput("rw_rst_gates_ready", lsu_req_ready, 1'b0);
        nextCycle();
        checkOutput("rw_respready", mem_resp_ready, 1'b0);
        checkOutput("rw_memvalid", mem_req_valid, 1'b0);
        checkOutput("rw_memaddr", mem_addr, 32'h0);
        checkOutput("rw_lsuvalid", lsu_resp_valid, 1'b0);
        rst = 1'b0;
        lsu_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hFFFF_FFFF;
        nextCycle();
        checkOutput("rw_no_resp", lsu_resp_valid | ifu_resp_valid, 1'b0);
        checkOutput("rw_ignore_stray", mem_resp_ready, 1'b0);
        mem_resp_valid = 1'b0;

        $display("[TB] timeout with silent memory");
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        #1;
        checkOutput("to_grant", ifu_req_ready, 1'b1);
        nextCycle();
        ifu_req_valid = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 255; k++) begin
            mem_req_ready = (k == 0);
            #1;
            if (ifu_resp_valid !== 1'b0) early = 1'b1;
            nextCycle();
        end
        mem_req_ready = 1'b0;
        #1;
        checkOutput("to_early", early, 1'b0);
        checkOutput("to_valid", ifu_resp_valid, 1'b1);
        checkOutput("to_data", ifu_resp_data, 32'h0);
        checkOutput("to_err", ifu_resp_err, 1'b1);
        nextCycle();
        #1;
        checkOutput("to_done", ifu_resp_valid, 1'b0);

        $display("[TB] response in the timeout cycle");
        ifu_req_valid = 1'b1;
        #1;
        checkOutput("tr_grant", ifu_req_ready, 1'b1);
        nextCycle();
        ifu_req_valid = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 255; k++) begin
            mem_req_ready = (k == 0);
            mem_resp_valid = (k == 254);
            mem_resp_data = 32'hCAFE_F00D;
            #1;
            if (ifu_resp_valid !== 1'b0) early = 1'b1;
            nextCycle();
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        checkOutput("tr_early", early, 1'b0);
        checkOutput("tr_valid", ifu_resp_valid, 1'b1);
        checkOutput("tr_data", ifu_resp_data, 32'hCAFE_F00D);
        checkOutput("tr_err", ifu_resp_err, 1'b0);
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
